// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates a single SRAM controller between video reads and
// buffered drawing-side writes. Reads are served at once while the arbiter is
// idle. Writes queue in a small FIFO and are issued only during video
// blanking, and only when no read is pending.
//
// Ports
//   CLK, RESETN      clock, asynchronous active-low reset
//   WR_REQ/ADDR/DATA drawing-side write request (pushed into the FIFO)
//   WR_FULL, WR_OVF  FIFO full, sticky dropped-write flag
//   VGA_BLANK        writes may start only while high
//   RD_REQ/ADDR      video-side read request
//   RD_DATA/VALID    registered read data and its update pulse
//   RD_MISS          pulse: the read of the previous cycle was not served
//   MEM_*            SRAM controller interface
module vram_arbiter #(
  parameter int FIFO_AW = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        WR_REQ,
  input  logic [17:0] WR_ADDR,
  input  logic [15:0] WR_DATA,
  output logic        WR_FULL,
  output logic        WR_OVF,
  input  logic        VGA_BLANK,
  input  logic        RD_REQ,
  input  logic [17:0] RD_ADDR,
  output logic [15:0] RD_DATA,
  output logic        RD_VALID,
  output logic        RD_MISS,
  output logic        MEM_STARTWRITE,
  output logic [17:0] MEM_ADDR,
  output logic [15:0] MEM_DATAWRITTEN,
  input  logic [15:0] MEM_DATAREAD,
  input  logic        MEM_WRITEREADY
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } wr_ent_t;

  typedef enum logic [1:0] {HOLD, IDLE, START, WAIT} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  wr_ent_t           fifo_q [DEPTH];
  logic [FIFO_AW:0]  wptr_q, rptr_q;
  wr_ent_t           cur_q;
  wr_ent_t           head;
  logic              full, empty, push, pop;
  logic              ovf_q, rd_valid_q, rd_miss_q;
  logic [15:0]       rd_data_q;

  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  // full is taken before this edge's pop, so a pop never frees room for a
  // push at the same edge
  assign push  = WR_REQ && !full;
  assign pop   = (state_q == START);
  assign head  = fifo_q[rptr_q[FIFO_AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push) fifo_q[wptr_q[FIFO_AW-1:0]] <= '{addr: WR_ADDR, data: WR_DATA};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD:  if (cnt_q == 2'd3) state_d = IDLE;
      IDLE:  if (!empty && VGA_BLANK && !RD_REQ) state_d = START;
      START: state_d = WAIT;
      WAIT:  if (MEM_WRITEREADY) state_d = IDLE;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      cur_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // HOLD lets any controller write in flight at reset drain out
      cnt_q   <= (state_q == HOLD) ? cnt_q + 2'd1 : 2'd0;
      if (push)             wptr_q <= wptr_q + 1'b1;
      if (WR_REQ && full)   ovf_q  <= 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        cur_q  <= head;
      end
      rd_valid_q <= RD_REQ && (state_q == IDLE);
      rd_miss_q  <= RD_REQ && (state_q != IDLE);
      if (RD_REQ && state_q == IDLE) rd_data_q <= MEM_DATAREAD;
    end
  end

  always_comb begin
    MEM_ADDR        = RD_ADDR;
    MEM_DATAWRITTEN = cur_q.data;
    MEM_STARTWRITE  = 1'b0;
    case (state_q)
      START: begin
        MEM_STARTWRITE  = 1'b1;
        MEM_ADDR        = head.addr;
        MEM_DATAWRITTEN = head.data;
      end
      WAIT:    MEM_ADDR = cur_q.addr;
      default: ;
    endcase
  end

  assign WR_FULL  = full;
  assign WR_OVF   = ovf_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign RD_MISS  = rd_miss_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 2, giving the log2 of the write FIFO depth (default depth 4).
REQ-002 The block SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESETN  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port WR_REQ  input  1  drawing-side pixel-word write request, sampled each cycle.
REQ-005 The block SHALL have port WR_ADDR  input  18  write word address.
REQ-006 The block SHALL have port WR_DATA  input  16  write word data.
REQ-007 The block SHALL have port WR_FULL  output  1  write FIFO holds 2**FIFO_AW entries.
REQ-008 The block SHALL have port WR_OVF  output  1  sticky flag: a write request was dropped.
REQ-009 The block SHALL have port VGA_BLANK  input  1  high during video blanking; writes start only while high.
REQ-010 The block SHALL have port RD_REQ  input  1  video-side read request.
REQ-011 The block SHALL have port RD_ADDR  input  18  read word address.
REQ-012 The block SHALL have port RD_DATA  output  16  registered read data.
REQ-013 The block SHALL have port RD_VALID  output  1  one-cycle pulse: RD_DATA updated.
REQ-014 The block SHALL have port RD_MISS  output  1  one-cycle pulse: read request not served.
REQ-015 The block SHALL have port MEM_STARTWRITE  output  1  write start to SRAM controller.
REQ-016 The block SHALL have port MEM_ADDR  output  18  address to SRAM controller.
REQ-017 The block SHALL have port MEM_DATAWRITTEN  output  16  write data to SRAM controller.
REQ-018 The block SHALL have port MEM_DATAREAD  input  16  combinational read data from SRAM controller.
REQ-019 The block SHALL have port MEM_WRITEREADY  input  1  controller in final write state.

Function
REQ-020 Write FIFO: depth 2**FIFO_AW, pointers FIFO_AW+1 bits wrapping modulo 2**(FIFO_AW+1); full = pointer MSBs differ and low bits equal; empty = pointers equal.
REQ-021 Push when WR_REQ=1 and FIFO not full at that edge; a pop at the same edge does not make room for that push.
REQ-022 WR_REQ=1 while full: entry dropped, WR_OVF set to 1 and held until reset.
REQ-023 FSM states: HOLD, IDLE, START, WAIT.
REQ-024 HOLD: entered on reset; 2-bit counter counts 0..3, move to IDLE after the 4th cycle; no writes issued; RD_REQ produces RD_MISS.
REQ-025 IDLE: MEM_ADDR = RD_ADDR; MEM_STARTWRITE = 0; on RD_REQ=1, RD_DATA <= MEM_DATAREAD and RD_VALID = 1 in the following cycle.
REQ-026 IDLE -> START when FIFO non-empty, VGA_BLANK=1 and RD_REQ=0 in the same cycle; reads have priority.
REQ-027 START (exactly 1 cycle): MEM_STARTWRITE = 1, MEM_ADDR/MEM_DATAWRITTEN = FIFO head; pop at the exiting edge; -> WAIT.
REQ-028 WAIT: MEM_ADDR/MEM_DATAWRITTEN held at the popped entry; -> IDLE on the edge where MEM_WRITEREADY=1.
REQ-029 RD_REQ=1 in START or WAIT: RD_MISS = 1 in the following cycle; RD_DATA unchanged.
REQ-030 VGA_BLANK falling during START/WAIT: the write completes normally.
REQ-031 Throughput: one FIFO word per 5 cycles (IDLE decision, START, 3 controller write cycles).
REQ-032 MEM_DATAWRITTEN holds its last value outside START/WAIT; it is zero after reset.
REQ-033 RD_VALID and RD_MISS are never high in the same cycle.

Reset
REQ-034 RESETN low asynchronously forces: state HOLD, counter 0, FIFO empty, WR_OVF 0, RD_DATA 0, RD_VALID 0, RD_MISS 0, MEM_STARTWRITE 0, MEM_DATAWRITTEN 0.
REQ-035 Reset during START/WAIT abandons the entry; the HOLD interval covers the in-flight controller write, which has no reset.

Verification
REQ-036 Reset release, RD_REQ=1 addr 0x00010 every cycle -> RD_MISS for 4 cycles, then RD_VALID with RD_DATA = word at 0x00010.
REQ-037 VGA_BLANK=1, push (0x00100, 0xBEEF) -> MEM_STARTWRITE pulses 2 cycles later for 1 cycle; read-back of 0x00100 returns 0xBEEF.
REQ-038 VGA_BLANK=0, push 5 words -> WR_FULL after the 4th push, 5th push dropped, WR_OVF=1; after blank rises, exactly 4 writes issued in push order.
REQ-039 RD_REQ held high with VGA_BLANK=1 and FIFO non-empty -> no MEM_STARTWRITE until RD_REQ drops.
REQ-040 RD_REQ during WAIT -> RD_MISS pulse, RD_DATA unchanged; the write still completes.
REQ-041 RESETN low during WAIT -> all outputs at reset values immediately; FIFO empty after release.
